// File: rtl/div_pkg.sv
// Shared definitions for the iterative RV64M divide/remainder unit.
package div_pkg;

  localparam int XLEN_DEF = 64;

  // Iteration counts for word (W) and full-width operations.
  localparam int ITER_W = 32;
  localparam int ITER_D = 64;

  // Operation encodings on the op input.
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } div_state_e;

  // DIV and REM treat their operands as two's complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // REM and REMU return the remainder rather than the quotient.
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift {rem, quot} left, trial-subtract
// the divisor from the remainder, keep the difference when it is non-negative.
module div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quot_o
);

  // The shifted remainder needs one extra bit: it can reach 2*dvsr-1.
  logic [XLEN:0] shifted;
  logic          ge;

  // Trial subtraction; the kept difference is below dvsr so it fits XLEN bits.
  always_comb begin
    shifted = {rem_i, quot_i[XLEN-1]};
    ge      = (shifted >= {1'b0, dvsr_i});
    rem_o   = ge ? (shifted[XLEN-1:0] - dvsr_i) : shifted[XLEN-1:0];
    quot_o  = {quot_i[XLEN-2:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV64M divide/remainder unit (DIV/DIVU/REM/REMU and W variants).
// Operands are reduced to magnitudes at accept time, divided one bit per
// cycle in CALC, and the signed fix-up is registered on entry to DONE.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | ready for a request; in_ready high
//   S_CALC | one restoring iteration per cycle, down-counter to zero
//   S_DONE | result held on wb_data until out_ready
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic            word,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            wb_en,
  output logic [4:0]      wb_addr,
  output logic [XLEN-1:0] wb_data,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN);

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic            word_q, word_d;
  logic            is_rem_q, is_rem_d;
  logic [4:0]      rd_q, rd_d;

  // Operand preparation signals (request side).
  logic            sgn_op;
  logic [XLEN-1:0] a_ext, b_ext;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN-1:0] most_neg;
  logic            div_zero, sgn_ovf;
  logic [XLEN-1:0] special_raw, special_res;

  // Iteration and fix-up signals (CALC side).
  logic [XLEN-1:0] step_rem, step_quot;
  logic [XLEN-1:0] q_fix, r_fix, fix_sel, fix_res;

  // Narrow to 32 bits for W ops, then split into sign and magnitude.
  always_comb begin
    sgn_op   = op_is_signed(op);
    a_ext    = rs1_data;
    b_ext    = rs2_data;
    most_neg = {1'b1, {(XLEN-1){1'b0}}};
    if (word) begin
      a_ext    = sgn_op ? sext32(rs1_data[31:0]) : {{(XLEN-32){1'b0}}, rs1_data[31:0]};
      b_ext    = sgn_op ? sext32(rs2_data[31:0]) : {{(XLEN-32){1'b0}}, rs2_data[31:0]};
      most_neg = sext32(32'h8000_0000);
    end
    a_neg    = sgn_op & a_ext[XLEN-1];
    b_neg    = sgn_op & b_ext[XLEN-1];
    a_abs    = a_neg ? -a_ext : a_ext;
    b_abs    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    sgn_ovf  = sgn_op && (a_ext == most_neg) && (b_ext == '1);
    if (div_zero) begin
      special_raw = op_is_rem(op) ? a_ext : '1;
    end else begin
      special_raw = op_is_rem(op) ? '0 : a_ext;
    end
    special_res = word ? sext32(special_raw[31:0]) : special_raw;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quot_o (step_quot)
  );

  // Signed fix-up of the final iteration's quotient/remainder magnitudes.
  always_comb begin
    q_fix   = neg_quo_q ? -step_quot : step_quot;
    r_fix   = neg_rem_q ? -step_rem  : step_rem;
    fix_sel = is_rem_q ? r_fix : q_fix;
    fix_res = word_q ? sext32(fix_sel[31:0]) : fix_sel;
  end

  // Next-state and datapath-load logic; flush wins over everything but rst.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    dvsr_d    = dvsr_q;
    res_d     = res_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    word_d    = word_q;
    is_rem_d  = is_rem_q;
    rd_d      = rd_q;
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      rem_d   = '0;
      quot_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            rd_d      = rd;
            word_d    = word;
            is_rem_d  = op_is_rem(op);
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            dvsr_d    = b_abs;
            rem_d     = '0;
            // W dividends sit in the top half so 32 shifts consume them.
            quot_d    = word ? (a_abs << 32) : a_abs;
            cnt_d     = word ? CNT_W'(ITER_W - 1) : CNT_W'(XLEN - 1);
            if (div_zero || sgn_ovf) begin
              res_d   = special_res;
              state_d = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_d  = step_rem;
          quot_d = step_quot;
          if (cnt_q == '0) begin
            res_d   = fix_res;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      dvsr_q    <= '0;
      res_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      word_q    <= 1'b0;
      is_rem_q  <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      dvsr_q    <= dvsr_d;
      res_q     <= res_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      word_q    <= word_d;
      is_rem_q  <= is_rem_d;
      rd_q      <= rd_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  // A flush in DONE discards the result, so it also suppresses the write.
  assign wb_en     = out_valid && out_ready && !flush && (rd_q != 5'd0);
  assign wb_addr   = rd_q;
  assign wb_data   = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, special
// cases, W variants, backpressure, x0 suppression, flush and reset abort.
module tb_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, word;
  logic [1:0]  op;
  logic [4:0]  rd;
  logic [63:0] rs1_data, rs2_data;
  logic        in_ready, out_valid, wb_en, busy;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;

  int checks = 0;
  int failures = 0;
  int wb_pulses = 0;

  div_unit #(.XLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .word      (word),
    .rd        (rd),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Count write-enable pulses, sampled mid-cycle.
  always @(negedge clk) if (wb_en) wb_pulses++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic w, input logic [4:0] r,
                       input logic [63:0] a, input logic [63:0] b);
    op = o; word = w; rd = r; rs1_data = a; rs2_data = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accepting edge.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic w,
                        input logic [4:0] r, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat);
    int cyc;
    int p0;
    p0 = wb_pulses;
    issue(o, w, r, a, b);
    wait_done(cyc);
    chk({tag, " lat"}, 64'(cyc), 64'(lat));
    chk({tag, " data"}, wb_data, exp);
    chk({tag, " addr"}, 64'(wb_addr), 64'(r));
    if (out_ready) begin
      chk({tag, " wb_en"}, 64'(wb_en), 64'(r != 5'd0));
      @(posedge clk); #1;
      chk({tag, " vld_clr"}, 64'(out_valid), 64'd0);
      chk({tag, " rdy_back"}, 64'(in_ready), 64'd1);
      chk({tag, " pulses"}, 64'(wb_pulses - p0), 64'(r != 5'd0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int p0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    word = 1'b0; op = 2'b00; rd = 5'd0; rs1_data = '0; rs2_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst wb_en", 64'(wb_en), 64'd0);
    chk("rst wb_addr", 64'(wb_addr), 64'd0);
    chk("rst wb_data", wb_data, 64'd0);
    rst = 1'b0;
    #1;
    chk("post rst in_ready", 64'(in_ready), 64'd1);

    // Unsigned / signed full-width
    run_op("divu 100/7", DIV_OP_DIVU, 1'b0, 5'd5, 64'd100, 64'd7, 64'd14, 65);
    run_op("remu 100/7", DIV_OP_REMU, 1'b0, 5'd5, 64'd100, 64'd7, 64'd2, 65);
    run_op("div -7/2", DIV_OP_DIV, 1'b0, 5'd3, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem -7/2", DIV_OP_REM, 1'b0, 5'd3, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("rem 7/-2", DIV_OP_REM, 1'b0, 5'd3, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);
    run_op("divu big", DIV_OP_DIVU, 1'b0, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000,
           64'h0000_0000_FFFF_FFFF, 65);
    run_op("div min/2", DIV_OP_DIV, 1'b0, 5'd8, 64'h8000_0000_0000_0000, 64'd2,
           64'hC000_0000_0000_0000, 65);

    // Special cases
    run_op("div 5/0", DIV_OP_DIV, 1'b0, 5'd4, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu 5/0", DIV_OP_REMU, 1'b0, 5'd4, 64'd5, 64'd0, 64'd5, 1);
    run_op("div ovf", DIV_OP_DIV, 1'b0, 5'd4, 64'h8000_0000_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    run_op("rem ovf", DIV_OP_REM, 1'b0, 5'd4, 64'h8000_0000_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);

    // W variants
    run_op("divw", DIV_OP_DIV, 1'b1, 5'd6, 64'h1_8000_0000, 64'd1,
           64'hFFFF_FFFF_8000_0000, 33);
    run_op("divuw", DIV_OP_DIVU, 1'b1, 5'd6, 64'hFFFF_FFFF, 64'd2, 64'h7FFF_FFFF, 33);
    run_op("remw -7/2", DIV_OP_REM, 1'b1, 5'd6, 64'h1234_5678_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, 33);
    run_op("divw ovf", DIV_OP_DIV, 1'b1, 5'd6, 64'h8000_0000, 64'hFFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1);
    run_op("divuw /0", DIV_OP_DIVU, 1'b1, 5'd6, 64'd7, 64'h5_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 1);

    // Backpressure with a real destination
    out_ready = 1'b0;
    p0 = wb_pulses;
    issue(DIV_OP_DIVU, 1'b0, 5'd9, 64'd100, 64'd7);
    wait_done(cyc);
    chk("bp lat", 64'(cyc), 64'd65);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp valid", 64'(out_valid), 64'd1);
      chk("bp data", wb_data, 64'd14);
      chk("bp addr", 64'(wb_addr), 64'd9);
      chk("bp in_ready", 64'(in_ready), 64'd0);
      chk("bp wb_en", 64'(wb_en), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp release wb_en", 64'(wb_en), 64'd1);
    @(posedge clk); #1;
    chk("bp vld_clr", 64'(out_valid), 64'd0);
    chk("bp pulses", 64'(wb_pulses - p0), 64'd1);

    // Backpressure with rd = x0
    out_ready = 1'b0;
    p0 = wb_pulses;
    issue(DIV_OP_DIV, 1'b0, 5'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    wait_done(cyc);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("x0 data", wb_data, 64'hFFFF_FFFF_FFFF_FFFD);
      chk("x0 wb_en", 64'(wb_en), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("x0 release wb_en", 64'(wb_en), 64'd0);
    @(posedge clk); #1;
    chk("x0 vld_clr", 64'(out_valid), 64'd0);
    chk("x0 pulses", 64'(wb_pulses - p0), 64'd0);

    // Flush during iteration 20
    p0 = wb_pulses;
    issue(DIV_OP_DIVU, 1'b0, 5'd7, 64'd100, 64'd7);
    repeat (19) @(posedge clk);
    #1;
    chk("fl mid busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl busy", 64'(busy), 64'd0);
    chk("fl valid", 64'(out_valid), 64'd0);
    chk("fl in_ready", 64'(in_ready), 64'd1);
    run_op("after flush", DIV_OP_REMU, 1'b0, 5'd7, 64'd100, 64'd7, 64'd2, 65);
    chk("fl pulses", 64'(wb_pulses - p0), 64'd1);

    // Flush in the accepting cycle drops the request
    op = DIV_OP_DIV; word = 1'b0; rd = 5'd2; rs1_data = 64'd5; rs2_data = 64'd0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("fl acc busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("fl acc valid", 64'(out_valid), 64'd0);

    // Reset mid-CALC
    p0 = wb_pulses;
    issue(DIV_OP_DIVU, 1'b0, 5'd11, 64'd100, 64'd7);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mr in_ready", 64'(in_ready), 64'd0);
    chk("mr busy", 64'(busy), 64'd0);
    chk("mr valid", 64'(out_valid), 64'd0);
    chk("mr wb_en", 64'(wb_en), 64'd0);
    chk("mr wb_addr", 64'(wb_addr), 64'd0);
    chk("mr wb_data", wb_data, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mr in_ready back", 64'(in_ready), 64'd1);
    chk("mr pulses", 64'(wb_pulses - p0), 64'd0);
    run_op("after rst", DIV_OP_DIVU, 1'b0, 5'd5, 64'd100, 64'd7, 64'd14, 65);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
